// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one trial subtraction per clock, N clocks per divide.
// Optional two's-complement operands when SIGNED_DIV_EN is defined.
module seq_restoring_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [N-1:0]  r, q, d;
    logic [CW-1:0] cnt;
    logic          accept, last;
    logic [N:0]    t;
    logic [N-1:0]  r_step, q_step, a_mag, b_mag, q_fin, r_fin;

    assign accept = start && (state != RUN);
    assign last   = (cnt == '0);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // The borrow of the (N+1)-bit trial subtract decides restore; a kept
    // remainder is always < D, so N stored bits of R are enough.
    always_comb begin
        t = {r, q[N-1]} - {1'b0, d};
        if (!t[N]) begin
            r_step = t[N-1:0];
            q_step = {q[N-2:0], 1'b1};
        end else begin
            r_step = {r[N-2:0], q[N-1]};
            q_step = {q[N-2:0], 1'b0};
        end
    end

`ifdef SIGNED_DIV_EN
    logic neg_q, neg_r;

    assign a_mag = dividend[N-1] ? -dividend : dividend;
    assign b_mag = divisor[N-1]  ? -divisor  : divisor;
    // Truncation toward zero; most-negative / -1 wraps back to most-negative.
    assign q_fin = neg_q ? -q_step : q_step;
    assign r_fin = neg_r ? -r_step : r_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[N-1] ^ divisor[N-1];
            neg_r <= dividend[N-1];
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fin = q_step;
    assign r_fin = r_step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
                else        state_nxt = IDLE;
            end
            RUN:     if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                r   <= '0;
                q   <= a_mag;
                d   <= b_mag;
                cnt <= CW'(N - 1);
            end
        end else if (state == RUN) begin
            r <= r_step;
            q <= q_step;
            if (last) begin
                quotient    <= q_fin;
                remainder   <= r_fin;
                div_by_zero <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (N=32); signed cases only when SIGNED_DIV_EN is defined.
module tb_seq_restoring_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    int total = 0, bad = 0;

    seq_restoring_divider #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Launch one divide and wait (bounded) for done; lat counts negedges after the accept edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int lat, output int bcnt);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #1;
        total++; if ({busy, done, div_by_zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, div_by_zero}); end
        total++; if (quotient !== 32'd0 || remainder !== 32'd0) begin bad++; $display("FAIL reset_results got q=%h r=%h want 0", quotient, remainder); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bcnt;
        run_div(32'd13, 32'd12, lat, bcnt);
        total++; if (lat !== 33) begin bad++; $display("FAIL basic_latency got=%0d want=33", lat); end
        total++; if (bcnt !== 32) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=32", bcnt); end
        total++; if (quotient !== 32'd1 || remainder !== 32'd1 || div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_13_12 got q=%0d r=%0d z=%b want q=1 r=1 z=0", quotient, remainder, div_by_zero); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
        total++; if (quotient !== 32'd1 || remainder !== 32'd1) begin bad++; $display("FAIL basic_hold got q=%0d r=%0d want 1 1", quotient, remainder); end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        run_div(32'd100, 32'd0, lat, bcnt);
        total++; if (lat !== 1 || bcnt !== 0) begin bad++; $display("FAIL dbz_latency got lat=%0d busy=%0d want 1 0", lat, bcnt); end
        total++; if (quotient !== 32'hFFFFFFFF || remainder !== 32'd100 || div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_result got q=%h r=%0d z=%b want ffffffff 100 1", quotient, remainder, div_by_zero); end
    endtask

    task automatic test_boundaries;
        int lat, bcnt;
        run_div(32'hFFFFFFFF, 32'h80000001, lat, bcnt);
        total++; if (quotient !== 32'd1 || remainder !== 32'h7FFFFFFE || div_by_zero !== 1'b0) begin bad++; $display("FAIL wide_divisor got q=%h r=%h z=%b want 1 7ffffffe 0", quotient, remainder, div_by_zero); end
        run_div(32'd5, 32'd9, lat, bcnt);
        total++; if (quotient !== 32'd0 || remainder !== 32'd5) begin bad++; $display("FAIL small_dividend got q=%0d r=%0d want 0 5", quotient, remainder); end
        run_div(32'd12345, 32'd1, lat, bcnt);
        total++; if (quotient !== 32'd12345 || remainder !== 32'd0) begin bad++; $display("FAIL divisor_one got q=%0d r=%0d want 12345 0", quotient, remainder); end
        run_div(32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        total++; if (quotient !== 32'd1 || remainder !== 32'd0) begin bad++; $display("FAIL max_by_max got q=%h r=%h want 1 0", quotient, remainder); end
        run_div(32'd1000000007, 32'd65536, lat, bcnt);
        total++; if (quotient !== 32'd15258 || remainder !== 32'd51719) begin bad++; $display("FAIL large got q=%0d r=%0d want 15258 51719", quotient, remainder); end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        bit stable;
        run_div(32'd7, 32'd2, lat, bcnt);
        total++; if (quotient !== 32'd3 || remainder !== 32'd1) begin bad++; $display("FAIL b2b_first got q=%0d r=%0d want 3 1", quotient, remainder); end
        dividend = 32'd1000; divisor = 32'd33; start = 1'b1;
        @(negedge clk); start = 1'b0; lat = 1; stable = 1'b1;
        while (!done && lat < 100) begin
            if (lat == 5 || lat == 20) begin dividend = 32'd999; divisor = 32'd3; start = 1'b1; end
            else start = 1'b0;
            if (quotient !== 32'd3 || remainder !== 32'd1) stable = 1'b0;
            @(negedge clk); lat++;
        end
        start = 1'b0;
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL b2b_stable got=%b want=1", stable); end
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", lat); end
        total++; if (quotient !== 32'd30 || remainder !== 32'd10) begin bad++; $display("FAIL b2b_second got q=%0d r=%0d want 30 10", quotient, remainder); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_reset_abort;
        int lat, bcnt, seen;
        @(negedge clk);
        dividend = 32'd50; divisor = 32'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_running got busy=%b want=1", busy); end
        rst_n = 1'b0; #1;
        total++; if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin bad++; $display("FAIL abort_async got flags=%b q=%h r=%h want 000 0 0", {busy, done, div_by_zero}, quotient, remainder); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; seen = 0;
        repeat (40) begin @(negedge clk); if (done || busy) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen); end
        run_div(32'd50, 32'd7, lat, bcnt);
        total++; if (quotient !== 32'd7 || remainder !== 32'd1 || lat !== 33) begin bad++; $display("FAIL abort_rerun got q=%0d r=%0d lat=%0d want 7 1 33", quotient, remainder, lat); end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed;
        int lat, bcnt;
        run_div(32'hFFFFFFF9, 32'd2, lat, bcnt);
        total++; if (quotient !== 32'hFFFFFFFD || remainder !== 32'hFFFFFFFF || lat !== 33) begin bad++; $display("FAIL signed_neg7_2 got q=%h r=%h lat=%0d want fffffffd ffffffff 33", quotient, remainder, lat); end
        run_div(32'd7, 32'hFFFFFFFE, lat, bcnt);
        total++; if (quotient !== 32'hFFFFFFFD || remainder !== 32'd1) begin bad++; $display("FAIL signed_7_neg2 got q=%h r=%h want fffffffd 1", quotient, remainder); end
        run_div(32'h80000000, 32'hFFFFFFFF, lat, bcnt);
        total++; if (quotient !== 32'h80000000 || remainder !== 32'd0) begin bad++; $display("FAIL signed_minint got q=%h r=%h want 80000000 0", quotient, remainder); end
        run_div(32'hFFFFFFF9, 32'd0, lat, bcnt);
        total++; if (quotient !== 32'hFFFFFFFF || remainder !== 32'hFFFFFFF9 || div_by_zero !== 1'b1) begin bad++; $display("FAIL signed_dbz got q=%h r=%h z=%b want ffffffff fffffff9 1", quotient, remainder, div_by_zero); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_boundaries;
        test_back_to_back;
        test_reset_abort;
`ifdef SIGNED_DIV_EN
        test_signed;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
